// File: rtl/mult_feeder.sv
// Multiply-switch feeder: emits one stationary operand per job, then streams
// a fixed number of buffered upstream words in arrival order.

module mult_feeder_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Extra pointer bit tells full (lap ahead) from empty (same lap).
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

module mult_feeder #(
    parameter int DATA_TYPE  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [DATA_TYPE-1:0] i_stat_data,
    input  logic [CNT_WIDTH-1:0] i_num,
    input  logic                 i_valid,
    input  logic [DATA_TYPE-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [DATA_TYPE-1:0] o_data,
    output logic                 o_stationary,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STAT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic                 valid_q, valid_d;
    logic [DATA_TYPE-1:0] data_q, data_d;
    logic                 stationary_q, stationary_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_TYPE-1:0] fifo_head;

    mult_feeder_fifo #(
        .WIDTH (DATA_TYPE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept),
        .push_data_i (i_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign o_ready = ((state_q == S_STAT) || (state_q == S_STREAM)) &&
                     !fifo_full && (acc_q < num_q);
    assign accept  = o_ready && i_valid;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        acc_d        = acc_q;
        sent_d       = sent_q;
        valid_d      = 1'b0;
        data_d       = '0;
        stationary_d = 1'b0;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The output register itself holds the latched stationary operand.
                if (i_start) begin
                    num_d        = i_num;
                    acc_d        = '0;
                    sent_d       = '0;
                    valid_d      = 1'b1;
                    stationary_d = 1'b1;
                    data_d       = i_stat_data;
                    state_d      = S_STAT;
                end
            end
            S_STAT: begin
                state_d = (num_q != '0) ? S_STREAM : S_DONE;
            end
            S_STREAM: begin
                if (sent_q == num_q) begin
                    state_d = S_DONE;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    data_d  = fifo_head;
                    sent_d  = sent_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            acc_d = acc_q + CNT_ONE;
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            num_q        <= '0;
            acc_q        <= '0;
            sent_q       <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            stationary_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            acc_q        <= acc_d;
            sent_q       <= sent_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            stationary_q <= stationary_d;
            done_q       <= done_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_stationary = stationary_q;
    assign o_done       = done_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule

// File: doc/mult_feeder.md
MULT_FEEDER -- requirements
Module: mult_feeder

Interface
REQ-001 SHALL have parameter DATA_TYPE, default 16, meaning width of stationary and streaming operands.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning streaming FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, meaning width of the job-length field and the counters.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 i_start  input  1  job start pulse; sampled only in IDLE.
REQ-007 i_stat_data  input  DATA_TYPE  stationary operand; latched with i_start.
REQ-008 i_num  input  CNT_WIDTH  number of streaming operands in the job; latched with i_start.
REQ-009 i_valid  input  1  upstream streaming word valid.
REQ-010 i_data  input  DATA_TYPE  upstream streaming word.
REQ-011 o_ready  output  1  feeder accepts i_data this cycle; transfer when i_valid && o_ready.
REQ-012 o_valid  output  1  word valid toward multiply switch (one word/cycle max, no backpressure).
REQ-013 o_data  output  DATA_TYPE  word toward multiply switch.
REQ-014 o_stationary  output  1  marks o_data as stationary value to be latched by the switch.
REQ-015 o_busy  output  1  high in any state other than IDLE.
REQ-016 o_done  output  1  one-cycle pulse at job completion.

Function
REQ-017 SHALL implement FSM states IDLE, STAT, STREAM, DONE.
REQ-018 IDLE: on i_start=1, latch i_stat_data and i_num, clear counters, go to STAT; i_start in any other state SHALL be ignored.
REQ-019 STAT: lasts exactly one cycle; o_valid=1, o_stationary=1, o_data=latched stationary value; next state STREAM if num>0, else DONE.
REQ-020 o_valid, o_data, o_stationary, o_done SHALL be registered; stationary word appears in the cycle after i_start is sampled.
REQ-021 Accept counter: o_ready = (state is STAT or STREAM) && FIFO not full && accepted < num; SHALL never accept more than num words per job.
REQ-022 STREAM: each cycle FIFO non-empty, SHALL pop head and drive it with o_valid=1, o_stationary=0 in the following cycle; o_valid=0 in cycles with empty FIFO.
REQ-023 Sent counter increments per popped word; when sent reaches num, next state DONE.
REQ-024 DONE: o_done=1 for exactly one cycle, then IDLE; o_valid=0 in DONE.
REQ-025 FIFO: first-in first-out, no bypass; a word accepted in cycle t SHALL appear on o_data no earlier than cycle t+2.
REQ-026 Simultaneous push and pop SHALL be supported when FIFO neither empty nor full; occupancy unchanged.
REQ-027 Push when full SHALL not occur (o_ready=0); pop when empty SHALL not occur.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.
REQ-029 i_num=0: job SHALL emit only the stationary word, then DONE; o_ready stays 0.
REQ-030 o_stationary=1 SHALL only coincide with o_valid=1, and exactly once per job.
REQ-031 Word order on o_data SHALL equal accept order on i_data; no drop, no duplicate.

Reset
REQ-032 rst=1 SHALL immediately (asynchronously) force state IDLE, flush FIFO, clear counters and latched values.
REQ-033 During and after reset: o_valid=0, o_data=0, o_stationary=0, o_ready=0, o_busy=0, o_done=0.
REQ-034 Reset mid-job SHALL abort the job without o_done; next i_start after release starts a fresh job.

Verification
REQ-035 Basic job: i_start, i_stat_data=0x0005, i_num=3, upstream sends 0x0001,0x0002,0x0003 back-to-back -> o_stationary word 0x0005 then 0x0001,0x0002,0x0003 with o_stationary=0, then o_done one pulse.
REQ-036 Zero length: i_num=0, i_stat_data=0x00AA -> single o_valid with o_stationary=1, o_data=0x00AA, o_done next, o_ready never 1.
REQ-037 Full FIFO: FIFO_DEPTH=8, i_num=20, upstream always valid -> o_ready never 1 while 8 entries held, all 20 words out in order, no overflow.
REQ-038 Bubbles: i_valid toggled 1/0 every cycle, i_num=4 -> o_valid gaps match, 4 streaming words out, i_start asserted mid-job ignored.
REQ-039 Reset mid-job: rst asserted after 2 of 5 streaming words output -> all outputs 0 same cycle, no o_done; new job with i_num=1 completes normally.
REQ-040 Over-supply: i_num=2, upstream offers 4 words -> only 2 accepted (o_ready drops after second), only 2 streamed.
